// File: rtl/doorlock_pkg.sv
// Shared definitions for the doorlock path: key codes, keypad scanner states
// and the (row, column) to key-code map of the 4x4 keypad.
package doorlock_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {SCAN, DEB_P, HELD, DEB_R} kp_state_e;

  function automatic logic [3:0] kp_decode(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parametrised two-flop synchroniser; resets to all-ones so that
// pulled-up inputs read as idle straight out of reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: drives one row at a time, debounces
// press and release, and hands one key code per press over valid/ready.
module keypad_scanner
  import doorlock_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEB_CNT  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] number_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overrun_o
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(DEB_CNT + 1);

  logic [3:0]    cs;
  logic [3:0]    cs_n;
  logic          one_key;
  logic [1:0]    col_enc;
  logic          col_rel;
  logic          dwell_last;
  logic [BW-1:0] deb_next;
  logic          deb_done;
  logic          accept;

  kp_state_e     state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0]    number_q, number_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (col_i),
    .q_o    (cs)
  );

  assign cs_n       = ~cs;
  assign one_key    = $onehot(cs_n);
  assign col_rel    = cs[col_q];
  assign dwell_last = (dwell_q == DW'(SCAN_DIV - 1));
  assign deb_next   = deb_q + BW'(1);
  assign deb_done   = (deb_next == BW'(DEB_CNT));
  assign accept     = valid_q & ready_i;

  always_comb begin
    col_enc = 2'd0;
    case (cs_n)
      4'b0010: col_enc = 2'd1;
      4'b0100: col_enc = 2'd2;
      4'b1000: col_enc = 2'd3;
      default: col_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    number_d  = number_q;
    valid_d   = valid_q & ~ready_i;
    overrun_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_last) begin
          dwell_d = '0;
          if (one_key) begin
            col_d   = col_enc;
            deb_d   = BW'(1);
            state_d = DEB_P;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEB_P: begin
        if (one_key && (col_enc == col_q)) begin
          deb_d = deb_next;
          if (deb_done) begin
            state_d = HELD;
            // A same-cycle accept frees the slot, so the new code wins.
            if (!valid_q || accept) begin
              number_d = kp_decode(row_q, col_q);
              valid_d  = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          dwell_d = '0;
        end
      end
      HELD: begin
        if (col_rel) begin
          state_d = DEB_R;
          deb_d   = BW'(1);
        end
      end
      DEB_R: begin
        if (col_rel) begin
          deb_d = deb_next;
          if (deb_done) begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            dwell_d = '0;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      number_q  <= 4'h0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_o     = ~(4'b0001 << row_q);
  assign number_o  = number_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model feeds the columns from the
// driven row; delivered codes are scored against the sequence of presses made.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] number_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       overrun_o;

  logic [15:0] pressed = 16'h0;   // bit r*4+c: key at row r, column c is down
  logic [3:0]  glitch  = 4'hF;    // forced-low column override
  logic        rand_rdy = 1'b0;
  logic        rdy_force = 1'b1;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];
  int         valid_cycles = 0;
  int         ovr_cnt = 0;
  logic       prev_pend = 1'b0;
  logic [3:0] prev_num = 4'h0;
  int         n_checks = 0;
  int         n_fail = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .col_i     (col_i),
    .row_o     (row_o),
    .number_o  (number_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!row_o[r] && pressed[r*4+k]) c[k] = 1'b0;
    col_i = c & glitch;
  end

  always @(posedge clk) begin
    #2;
    ready_i = rand_rdy ? 1'($urandom_range(1)) : rdy_force;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o) valid_cycles++;
      if (overrun_o) ovr_cnt++;
      if (valid_o && ready_i) got_q.push_back(number_o);
      if (prev_pend && valid_o) check("hold_stable", {28'h0, number_o}, {28'h0, prev_num});
      prev_pend = valid_o && !ready_i;
      prev_num  = number_o;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_score();
    got_q.delete();
    exp_q.delete();
    valid_cycles = 0;
    ovr_cnt = 0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    pressed = 16'h0;
    glitch = 4'hF;
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    cyc(3);
    @(negedge clk);
    rst_ni = 1'b1;
    clear_score();
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_code"}, {28'h0, got_q[i]}, {28'h0, exp_q[i]});
  endtask

  initial begin
    // Test 1: reset values and idle scan cadence
    do_reset();
    check("rst_row", {28'h0, row_o}, 32'hE);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_number", {28'h0, number_o}, 32'h0);
    check("rst_overrun", {31'h0, overrun_o}, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      check("scan_row", {28'h0, row_o}, {28'h0, exp_row});
    end
    check("idle_valid", valid_cycles, 0);

    // Test 2: key '5' held, released
    do_reset();
    pressed[5] = 1'b1;
    cyc(40);
    pressed = 16'h0;
    cyc(40);
    exp_q.push_back(4'h5);
    score("key5");
    check("key5_pulses", valid_cycles, 1);

    // Test 3: '#' pending, '7' overruns
    do_reset();
    rdy_force = 1'b0;
    pressed[14] = 1'b1;
    cyc(40);
    pressed = 16'h0;
    cyc(40);
    pressed[8] = 1'b1;
    cyc(40);
    pressed = 16'h0;
    cyc(40);
    check("ovr_number", {28'h0, number_o}, 32'hF);
    check("ovr_valid", {31'h0, valid_o}, 32'h1);
    check("ovr_pulses", ovr_cnt, 1);
    rdy_force = 1'b1;
    @(negedge clk);
    check("ovr_acc_valid", {31'h0, valid_o}, 32'h1);
    @(negedge clk);
    check("ovr_clear", {31'h0, valid_o}, 32'h0);
    exp_q.push_back(4'hF);
    cyc(20);
    score("ovr");

    // Test 4: two-cycle glitch on column 0 at the row-0 sample
    do_reset();
    @(negedge clk);
    glitch = 4'hE;
    @(negedge clk);
    @(negedge clk);
    glitch = 4'hF;
    @(negedge clk);
    check("glitch_hold_row", {28'h0, row_o}, 32'hE);
    @(negedge clk);
    @(negedge clk);
    check("glitch_next_row", {28'h0, row_o}, 32'hD);
    cyc(40);
    score("glitch");
    check("glitch_valid", valid_cycles, 0);

    // Test 5: '2' bounces on release
    do_reset();
    pressed[1] = 1'b1;
    cyc(40);
    pressed = 16'h0;
    cyc(1);
    pressed[1] = 1'b1;
    cyc(1);
    pressed = 16'h0;
    cyc(40);
    exp_q.push_back(4'h2);
    score("bounce");
    check("bounce_pulses", valid_cycles, 1);

    // Test 6a: two keys in one row
    do_reset();
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    cyc(60);
    pressed = 16'h0;
    cyc(30);
    score("multi");

    // Test 6b: reset while '9' held with code pending
    do_reset();
    rdy_force = 1'b0;
    pressed[10] = 1'b1;
    cyc(40);
    check("pre_rst_valid", {31'h0, valid_o}, 32'h1);
    check("pre_rst_number", {28'h0, number_o}, 32'h9);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_valid", {31'h0, valid_o}, 32'h0);
    check("async_number", {28'h0, number_o}, 32'h0);
    check("async_row", {28'h0, row_o}, 32'hE);
    pressed = 16'h0;
    cyc(3);
    @(negedge clk);
    rst_ni = 1'b1;
    rdy_force = 1'b1;
    clear_score();
    cyc(60);
    score("post_rst");
    check("post_rst_valid", valid_cycles, 0);

    // Randomised presses with a stalling consumer
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(15);
      pressed = 16'h0;
      pressed[k] = 1'b1;
      cyc($urandom_range(60, 30));
      pressed = 16'h0;
      cyc($urandom_range(60, 40));
      exp_q.push_back(keymap[k]);
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    cyc(10);
    score("rand");
    check("rand_overrun", ovr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
